// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request, response and loader write port.
interface imem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_inst_o;
  logic [63:0] resp_addr_o;
  logic [1:0]  resp_fault_o;
  logic        wr_en_i;
  logic [63:0] wr_addr_i;
  logic [31:0] wr_data_i;

  modport slave (
    input  req_valid_i, req_addr_i, flush_i, resp_ready_i,
    input  wr_en_i, wr_addr_i, wr_data_i,
    output req_ready_o, resp_valid_o, resp_inst_o, resp_addr_o, resp_fault_o
  );

  modport master (
    output req_valid_i, req_addr_i, flush_i, resp_ready_i,
    output wr_en_i, wr_addr_i, wr_data_i,
    input  req_ready_o, resp_valid_o, resp_inst_o, resp_addr_o, resp_fault_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency read pipeline feeding an in-order response queue,
// with redirect flush and a loader write port.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] NOP         = 32'h0000_0013
) (
  input  logic             clock,
  input  logic             reset,
  imem_responder_if.slave  bus
);

  localparam int unsigned QDEPTH     = LATENCY + 1;
  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam int unsigned QW         = $clog2(QDEPTH);
  localparam int unsigned CW         = $clog2(QDEPTH + 1);
  localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd4;

  function automatic logic [1:0] classify(input logic [63:0] addr);
    logic [1:0] f;
    if (addr[1:0] != 2'b00) begin
      f = 2'd1;
    end else if ((addr < BASE_ADDR) || (addr >= LIMIT_ADDR)) begin
      f = 2'd2;
    end else begin
      f = 2'd0;
    end
    return f;
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [63:0] addr);
    return AW'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
    logic [QW-1:0] n;
    if (p == QW'(QDEPTH - 1)) begin
      n = {QW{1'b0}};
    end else begin
      n = p + QW'(1);
    end
    return n;
  endfunction

  logic [31:0]   mem_r       [DEPTH_WORDS];
  logic          stg_valid_r [1:LATENCY];
  logic [31:0]   stg_inst_r  [1:LATENCY];
  logic [63:0]   stg_addr_r  [1:LATENCY];
  logic [1:0]    stg_fault_r [1:LATENCY];
  logic [31:0]   q_inst_r    [QDEPTH];
  logic [63:0]   q_addr_r    [QDEPTH];
  logic [1:0]    q_fault_r   [QDEPTH];
  logic [QW-1:0] rd_ptr_r;
  logic [QW-1:0] wr_ptr_r;
  logic [CW-1:0] q_cnt_r;
  logic [CW-1:0] count_r;

  logic          req_ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          clear_s;
  logic [1:0]    rd_fault_s;
  logic [31:0]   rd_inst_s;
  logic          resp_valid_s;
  logic [31:0]   resp_inst_s;
  logic [63:0]   resp_addr_s;
  logic [1:0]    resp_fault_s;

  // Request acceptance, array read and queue push/pop decisions.
  always_comb begin
    req_ready_s = !reset && !bus.flush_i && (count_r < CW'(QDEPTH));
    accept_s    = bus.req_valid_i && req_ready_s;
    rd_fault_s  = classify(bus.req_addr_i);
    if (rd_fault_s == 2'd0) begin
      rd_inst_s = mem_r[word_index(bus.req_addr_i)];
    end else begin
      rd_inst_s = NOP;
    end
    push_s  = stg_valid_r[LATENCY];
    pop_s   = (q_cnt_r != CW'(0)) && bus.resp_ready_i;
    clear_s = reset || bus.flush_i;
  end

  // Response port shows the queue head, or idle defaults when the queue is empty.
  always_comb begin
    if (q_cnt_r != CW'(0)) begin
      resp_valid_s = 1'b1;
      resp_inst_s  = q_inst_r[rd_ptr_r];
      resp_addr_s  = q_addr_r[rd_ptr_r];
      resp_fault_s = q_fault_r[rd_ptr_r];
    end else begin
      resp_valid_s = 1'b0;
      resp_inst_s  = NOP;
      resp_addr_s  = 64'd0;
      resp_fault_s = 2'd0;
    end
  end

  assign bus.req_ready_o  = req_ready_s;
  assign bus.resp_valid_o = resp_valid_s;
  assign bus.resp_inst_o  = resp_inst_s;
  assign bus.resp_addr_o  = resp_addr_s;
  assign bus.resp_fault_o = resp_fault_s;

  // Control state: stage valids, queue pointers and the outstanding count; flush clears them all.
  always_ff @(posedge clock) begin
    if (clear_s) begin
      for (int unsigned k = 1; k <= LATENCY; k++) begin
        stg_valid_r[k] <= 1'b0;
      end
      rd_ptr_r <= {QW{1'b0}};
      wr_ptr_r <= {QW{1'b0}};
      q_cnt_r  <= CW'(0);
      count_r  <= CW'(0);
    end else begin
      stg_valid_r[1] <= accept_s;
      for (int unsigned k = 2; k <= LATENCY; k++) begin
        stg_valid_r[k] <= stg_valid_r[k-1];
      end
      if (push_s) begin
        wr_ptr_r <= q_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= q_next(rd_ptr_r);
      end
      // count spans pipeline plus queue, so a push can never find the queue full.
      q_cnt_r <= q_cnt_r + CW'(push_s) - CW'(pop_s);
      count_r <= count_r + CW'(accept_s) - CW'(pop_s);
    end
  end

  // Payload path: pipeline stages shift unconditionally, queue slots written on push.
  always_ff @(posedge clock) begin
    stg_inst_r[1]  <= rd_inst_s;
    stg_addr_r[1]  <= bus.req_addr_i;
    stg_fault_r[1] <= rd_fault_s;
    for (int unsigned k = 2; k <= LATENCY; k++) begin
      stg_inst_r[k]  <= stg_inst_r[k-1];
      stg_addr_r[k]  <= stg_addr_r[k-1];
      stg_fault_r[k] <= stg_fault_r[k-1];
    end
    if (push_s) begin
      q_inst_r[wr_ptr_r]  <= stg_inst_r[LATENCY];
      q_addr_r[wr_ptr_r]  <= stg_addr_r[LATENCY];
      q_fault_r[wr_ptr_r] <= stg_fault_r[LATENCY];
    end
  end

  // Loader write; the read above sees the pre-write contents in the same cycle.
  always_ff @(posedge clock) begin
    if (bus.wr_en_i && (classify(bus.wr_addr_i) == 2'd0)) begin
      mem_r[word_index(bus.wr_addr_i)] <= bus.wr_data_i;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table of fault/latency vectors, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_imem_responder;

  localparam int          LATENCY = 2;
  localparam int          QDEPTH  = LATENCY + 1;
  localparam int          DEPTH   = 4096;
  localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LIMIT   = BASE + 64'd16384;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] addr;
    logic [1:0]  fault;
    int          elig;
  } rsp_t;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  fault;
    logic [31:0] inst;
  } vec_t;

  logic clock;
  logic reset;
  imem_responder_if bus();

  imem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE),
    .LATENCY(LATENCY),
    .NOP(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_vec;
  int          n_err;
  int          cyc;
  rsp_t        model_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic        s_ready, s_valid;
  logic [31:0] s_inst;
  logic [63:0] s_addr;
  logic [1:0]  s_fault;

  function automatic logic [1:0] fault_of(input logic [63:0] a);
    if (a % 64'd4 != 64'd0) return 2'd1;
    if (a < BASE || a >= LIMIT) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Sample and check the DUT against the model, advance the model, then move to the next cycle.
  task automatic cycle();
    logic  exp_ready, head_ok;
    rsp_t  r;
    #1;
    s_ready = bus.req_ready_o;
    s_valid = bus.resp_valid_o;
    s_inst  = bus.resp_inst_o;
    s_addr  = bus.resp_addr_o;
    s_fault = bus.resp_fault_o;
    exp_ready = !reset && !bus.flush_i && (model_q.size() < QDEPTH);
    head_ok   = (model_q.size() > 0) && (model_q[0].elig <= cyc);
    chk("req_ready", s_ready, exp_ready);
    chk("resp_valid", s_valid, head_ok);
    chk("resp_inst", s_inst, head_ok ? model_q[0].inst : NOP);
    chk("resp_addr", s_addr, head_ok ? model_q[0].addr : 64'd0);
    chk("resp_fault", s_fault, head_ok ? model_q[0].fault : 2'd0);
    if (head_ok && bus.resp_ready_i) void'(model_q.pop_front());
    if (reset || bus.flush_i) begin
      model_q.delete();
    end else if (bus.req_valid_i && exp_ready) begin
      r.addr  = bus.req_addr_i;
      r.fault = fault_of(bus.req_addr_i);
      r.inst  = (r.fault == 2'd0) ? ref_mem[int'((bus.req_addr_i - BASE) / 64'd4)] : NOP;
      r.elig  = cyc + LATENCY + 1;
      model_q.push_back(r);
    end
    if (bus.wr_en_i && fault_of(bus.wr_addr_i) == 2'd0)
      ref_mem[int'((bus.wr_addr_i - BASE) / 64'd4)] = bus.wr_data_i;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle();
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = BASE;
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b1;
    bus.wr_en_i      = 1'b0;
    bus.wr_addr_i    = BASE;
    bus.wr_data_i    = 32'd0;
  endtask

  task automatic wait_resp(output logic found, output int waited);
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      waited++;
      if (s_valid) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic request(input logic [63:0] a);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    cycle();
    bus.req_valid_i = 1'b0;
  endtask

  vec_t        tbl[10];
  logic        found;
  int          waited;
  int          n_acc;
  logic [31:0] got[2];
  int          n_got;
  int          sel;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    reset = 1'b1;
    idle();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    cycle();
    chk("reset_resp_valid", s_valid, 1'b0);
    chk("reset_req_ready", s_ready, 1'b0);
    reset = 1'b0;

    // Fill the whole array through the loader, then plant known words.
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = BASE + 64'(i) * 64'd4;
      bus.wr_data_i = $urandom;
      cycle();
    end
    bus.wr_addr_i = BASE;                 bus.wr_data_i = 32'h0000_0013; cycle();
    bus.wr_addr_i = BASE + 64'd4;         bus.wr_data_i = 32'h0010_0093; cycle();
    bus.wr_addr_i = BASE + 64'd8;         bus.wr_data_i = 32'h0020_0113; cycle();
    bus.wr_addr_i = BASE + 64'h3FFC;      bus.wr_data_i = 32'hCAFE_F00D; cycle();
    bus.wr_addr_i = BASE + 64'h4000;      bus.wr_data_i = 32'h1111_1111; cycle();
    bus.wr_addr_i = BASE + 64'd6;         bus.wr_data_i = 32'h2222_2222; cycle();
    idle();

    tbl[0] = '{64'h8000_0000, 2'd0, 32'h0000_0013};
    tbl[1] = '{64'h8000_0004, 2'd0, 32'h0010_0093};
    tbl[2] = '{64'h8000_0008, 2'd0, 32'h0020_0113};
    tbl[3] = '{64'h8000_3FFC, 2'd0, 32'hCAFE_F00D};
    tbl[4] = '{64'h8000_0002, 2'd1, NOP};
    tbl[5] = '{64'h8000_0001, 2'd1, NOP};
    tbl[6] = '{64'h7FFF_FFFC, 2'd2, NOP};
    tbl[7] = '{64'h8000_4000, 2'd2, NOP};
    tbl[8] = '{64'h7FFF_FFFE, 2'd1, NOP};
    tbl[9] = '{64'hFFFF_FFFF_8000_0000, 2'd2, NOP};
    for (int i = 0; i < 10; i++) begin
      request(tbl[i].addr);
      chk("tbl_accept", s_ready, 1'b1);
      wait_resp(found, waited);
      chk("tbl_found", found, 1'b1);
      chk("tbl_latency", 64'(waited), 64'(LATENCY + 1));
      chk("tbl_inst", s_inst, tbl[i].inst);
      chk("tbl_addr", s_addr, tbl[i].addr);
      chk("tbl_fault", s_fault, tbl[i].fault);
    end

    // Back-to-back fetches return on consecutive cycles.
    idle();
    request(BASE);          chk("b2b_ready0", s_ready, 1'b1);
    request(BASE + 64'd4);  chk("b2b_ready1", s_ready, 1'b1);
    request(BASE + 64'd8);  chk("b2b_ready2", s_ready, 1'b1);
    cycle(); chk("b2b_v0", s_valid, 1'b1); chk("b2b_a0", s_addr, BASE);         chk("b2b_i0", s_inst, 32'h0000_0013);
    cycle(); chk("b2b_v1", s_valid, 1'b1); chk("b2b_a1", s_addr, BASE + 64'd4); chk("b2b_i1", s_inst, 32'h0010_0093);
    cycle(); chk("b2b_v2", s_valid, 1'b1); chk("b2b_a2", s_addr, BASE + 64'd8); chk("b2b_i2", s_inst, 32'h0020_0113);
    cycle(); chk("b2b_v3", s_valid, 1'b0);

    // Backpressure: exactly QDEPTH accepted, ready returns the cycle after the first pop.
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i  = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.req_addr_i = BASE + 64'(i % 3) * 64'd4;
      cycle();
      if (s_ready) n_acc++;
    end
    chk("bp_accepts", 64'(n_acc), 64'(QDEPTH));
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    cycle(); chk("bp_pop_v", s_valid, 1'b1); chk("bp_pop_rdy", s_ready, 1'b0); chk("bp_a0", s_addr, BASE);
    cycle(); chk("bp_rdy_back", s_ready, 1'b1); chk("bp_a1", s_addr, BASE + 64'd4);
    cycle(); chk("bp_a2", s_addr, BASE + 64'd8);
    cycle(); chk("bp_empty", s_valid, 1'b0);

    // Flush kills both in-flight fetches; the next fetch comes back alone.
    idle();
    request(BASE);
    request(BASE + 64'd4);
    bus.flush_i = 1'b1;
    request(BASE);
    chk("flush_blocks_ready", s_ready, 1'b0);
    bus.flush_i = 1'b0;
    request(BASE + 64'd8);
    chk("post_flush_ready", s_ready, 1'b1);
    chk("post_flush_valid", s_valid, 1'b0);
    wait_resp(found, waited);
    chk("flush_found", found, 1'b1);
    chk("flush_addr", s_addr, BASE + 64'd8);
    chk("flush_inst", s_inst, 32'h0020_0113);

    // Same-cycle write and read of one word returns the old contents.
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = BASE;
    bus.wr_data_i = 32'hDEAD_BEEF;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = BASE;
    cycle();
    bus.wr_en_i = 1'b0;
    request(BASE);
    n_got = 0;
    for (int i = 0; i < 10 && n_got < 2; i++) begin
      cycle();
      if (s_valid) begin
        got[n_got] = s_inst;
        n_got++;
      end
    end
    chk("rf_count", 64'(n_got), 64'd2);
    chk("rf_old", got[0], 32'h0000_0013);
    chk("rf_new", got[1], 32'hDEAD_BEEF);

    // Reset with responses outstanding drops them; array contents survive.
    bus.resp_ready_i = 1'b0;
    request(BASE + 64'd4);
    request(BASE + 64'd8);
    cycle(); cycle(); cycle();
    chk("rst_pre_valid", s_valid, 1'b1);
    reset = 1'b1;
    cycle(); chk("rst_ready_low", s_ready, 1'b0);
    cycle(); chk("rst_valid_low", s_valid, 1'b0); chk("rst_ready_low2", s_ready, 1'b0);
    reset = 1'b0;
    bus.resp_ready_i = 1'b1;
    request(BASE + 64'd4);
    chk("rst_after_ready", s_ready, 1'b1);
    wait_resp(found, waited);
    chk("rst_after_found", found, 1'b1);
    chk("rst_after_inst", s_inst, 32'h0010_0093);
    chk("rst_after_addr", s_addr, BASE + 64'd4);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid_i  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel <= 6)      bus.req_addr_i = BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd4;
      else if (sel == 7) bus.req_addr_i = BASE + 64'($urandom_range(0, 16383)) | 64'd1;
      else if (sel == 8) bus.req_addr_i = BASE - 64'($urandom_range(1, 100)) * 64'd4;
      else               bus.req_addr_i = LIMIT + 64'($urandom_range(0, 100)) * 64'd4;
      bus.resp_ready_i = ($urandom_range(0, 9) < 7);
      bus.flush_i      = ($urandom_range(0, 99) < 3);
      reset            = ($urandom_range(0, 99) < 1);
      bus.wr_en_i      = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 9) == 0) bus.wr_addr_i = LIMIT + 64'($urandom_range(0, 15)) * 64'd4;
      else bus.wr_addr_i = BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd4 + 64'($urandom_range(0, 1)) * 64'd2;
      bus.wr_data_i    = $urandom;
      cycle();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface. It accepts word-fetch requests carrying a 64-bit PC and returns the 32-bit instruction after a fixed pipeline latency.
- Responses come out through a valid/ready handshake backed by a small response queue, so fetch backpressure never drops words.
- A branch/redirect flush kills all in-flight and queued responses.
- A 32-bit loader write port fills the array; used by the testbench and boot loader.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the array; power of 2.
- BASE_ADDR, 64'h0000_0000_8000_0000: byte address of word 0; equals the fetch reset PC.
- LATENCY, 2: cycles from request accept to response eligible; legal range 1..4.
- QDEPTH, LATENCY+1: maximum outstanding responses (pipeline plus queue).
- NOP, 32'h0000_0013: instruction returned on fault or when idle.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_addr_i  in  64  fetch byte address (PC)
- flush_i  in  1  redirect; discard everything outstanding
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  consumer accepts response
- resp_inst_o  out  32  instruction word
- resp_addr_o  out  64  PC the word belongs to
- resp_fault_o  out  2  0 ok, 1 misaligned, 2 access fault (out of range)
- wr_en_i  in  1  loader write enable
- wr_addr_i  in  64  loader byte address, word aligned
- wr_data_i  in  32  loader data

Behaviour:
- Reset (synchronous, active-high), taking effect next edge:
  - all pipeline-stage valids, queue pointers and the outstanding count are 0;
  - resp_valid_o=0, resp_inst_o=NOP, resp_addr_o=0, resp_fault_o=0;
  - req_ready_o=0 while reset is high;
  - array contents are not cleared.
- req_ready_o = !reset && !flush_i && (count < QDEPTH). It depends only on registered count; it does not look through a same-cycle response pop.
- Accept (req_valid_i && req_ready_o):
  - the array read, fault classification and address capture happen in the accept cycle;
  - the result enters pipeline stage 1 and shifts one stage per cycle regardless of backpressure;
  - after LATENCY edges it is pushed into the response queue (FIFO, depth QDEPTH).
- count tracks outstanding responses:
  - +1 on accept, −1 on response handshake, net 0 when both occur;
  - because count bounds pipeline plus queue, the queue can never overflow.
- Response output:
  - resp_* show the queue head and resp_valid_o = queue not empty;
  - with an empty queue, resp_inst_o=NOP, resp_addr_o=0, resp_fault_o=0;
  - a word exiting the pipeline into an empty queue appears on the next cycle. Minimum request-to-response latency is LATENCY+1 cycles: LATENCY=2 gives accept at edge N, resp_valid_o high after edge N+3.
  - Handshake is resp_valid_o && resp_ready_i; the head pops and the next entry appears the following cycle.
  - Responses return strictly in request order.
- Fault rules:
  - req_addr_i[1:0]!=0 gives fault 1;
  - otherwise, an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) gives fault 2;
  - on fault, resp_inst_o=NOP and resp_addr_o=req_addr_i;
  - faulting requests occupy a slot and return normally.
- Array index = (addr−BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits, and used only when in range.
- Loader write:
  - on wr_en_i, the word at the wr_addr_i index is written at the edge;
  - out-of-range or misaligned writes are ignored;
  - a write and an accepted read to the same word in the same cycle: the read returns OLD data (read-first).
- Flush:
  - flush_i high forces req_ready_o low, so a same-cycle request is not accepted;
  - at the edge, all stage valids, the queue and count clear;
  - a same-cycle response handshake is still honoured (the consumer took it), then everything clears;
  - resp_valid_o=0 the cycle after flush;
  - a flush with nothing outstanding is a no-op.
- Reset during outstanding requests behaves like flush plus reset defaults; no response survives.
- Throughput: with resp_ready_i held high, one response per cycle sustained.

Test Plan:
- Load words 0x00000013, 0x00100093, 0x00200113 at 0x80000000/4/8; request those 3 addresses back-to-back, resp_ready_i=1 → responses on 3 consecutive cycles, first one LATENCY+1 cycles after the first accept, addrs in order, fault=0.
- resp_ready_i=0, issue requests continuously → exactly QDEPTH=3 accepted, then req_ready_o=0. Raise resp_ready_i → 3 responses in order; req_ready_o returns to 1 the cycle after the first pop.
- Request 0x80000002 → fault=1, inst=0x00000013. Request 0x7FFFFFFC and 0x80004000 → fault=2, inst=NOP.
- Issue 2 requests, assert flush_i the cycle after the second accept → neither response ever appears; a request at 0x80000008 the next cycle returns 0x00200113.
- In the same cycle, write 0xDEADBEEF to 0x80000000 and accept a read of 0x80000000 → response 0x00000013. A read the next cycle → 0xDEADBEEF.
- Assert reset with 2 outstanding requests and resp_valid_o high → next cycle resp_valid_o=0, req_ready_o=0 during reset; after release, a fresh request works and the array is retained.
